// File: rtl/uart_rx_frame.sv
// UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// valid/ready holding register with framing, parity and overrun reporting.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_rx_frame: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state;
    state_t state_next;

    logic                 sync_p0;
    logic                 rxs;
    logic [TW-1:0]        tick;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 stop_bad;

    logic                 tick_done;
    logic                 sample_data;
    logic                 sample_par;
    logic                 sample_stop;
    logic                 frame_done;

    logic                 done_p1;
    logic [DATA_BITS-1:0] word_p1;
    logic                 fe_p1;
    logic                 pe_p1;
    logic                 load;

    // Returns 1 when the data word plus received parity bit disagree with the mode.
    function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY == 1)
            return ~x;
        else if (PARITY == 2)
            return x;
        else
            return 1'b0;
    endfunction

    // ---- stage p0: line synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            sync_p0 <= rx_in;
            rxs     <= sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        tick_done   = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs)
                    state_next = S_START;
            end
            S_START: begin
                tick_done = (tick == TICK_HALF);
                if (tick_done)
                    state_next = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                tick_done   = (tick == TICK_FULL);
                sample_data = tick_done;
                if (tick_done && bit_cnt == LAST_DATA)
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tick_done  = (tick == TICK_FULL);
                sample_par = tick_done;
                if (tick_done)
                    state_next = S_STOP;
            end
            S_STOP: begin
                tick_done   = (tick == TICK_FULL);
                sample_stop = tick_done;
                if (tick_done && bit_cnt == LAST_STOP) begin
                    frame_done = 1'b1;
                    // Leaving half a bit early lets the next start edge be caught.
                    state_next = rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state_next != state || tick_done || state == S_IDLE || state == S_BREAK)
            tick <= '0;
        else
            tick <= tick + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || state_next != state)
            bit_cnt <= '0;
        else if (sample_data || sample_stop)
            bit_cnt <= bit_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (sample_data)
            shift <= {rxs, shift[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE) begin
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            if (sample_par)
                par_bad <= parity_fail(shift, rxs);
            if (sample_stop && !rxs)
                stop_bad <= 1'b1;
        end
    end

    // ---- stage p1: completed frame, one cycle after the last stop sample
    always_ff @(posedge clk) begin
        if (reset)
            done_p1 <= 1'b0;
        else
            done_p1 <= frame_done;
    end

    always_ff @(posedge clk) begin
        if (frame_done) begin
            word_p1 <= shift;
            fe_p1   <= stop_bad | ~rxs;
            pe_p1   <= par_bad;
        end
    end

    assign load = done_p1 && (!rx_valid || rx_ready);

    // ---- stage p2: holding register and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= done_p1 && rx_valid && !rx_ready;
            if (load) begin
                rx_data    <= word_p1;
                frame_err  <= fe_p1;
                parity_err <= pe_p1;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8N1 instance and an 8E2 instance,
// both at 16 clocks per bit.
module tb_uart_rx_frame;

    localparam int CPB = 16;
    localparam int LAT0 = CPB / 2 + (8 + 0 + 1) * CPB + 1;
    localparam int LAT1 = CPB / 2 + (8 + 1 + 2) * CPB + 1;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx0, rx1, rdy0, rdy1;
    logic [7:0] data0, data1;
    logic       vld0, vld1, fe0, fe1, pe0, pe1, ovr0, ovr1, busy0, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rise0 = 0, fall0 = 0, rise1 = 0;
    int   ovr_cycles0 = 0, ovr_cycles1 = 0;
    logic bp0 = 1'b0, bp1 = 1'b0, vp0 = 1'b0, vp1 = 1'b0;

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .rx_in(rx0), .rx_data(data0), .rx_valid(vld0),
        .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .rx_in(rx1), .rx_data(data1), .rx_valid(vld1),
        .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ovr1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int ch, input logic b);
        if (ch == 0) rx0 = b;
        else         rx1 = b;
        tick(CPB);
    endtask

    task automatic send(input int ch, input logic [7:0] d, input logic pbit,
                        input logic stop_lvl, input bit expect_word);
        exp_t e;
        e.data = d;
        e.fe   = ~stop_lvl;
        e.pe   = (ch == 1) ? ((^d) ^ pbit) : 1'b0;
        if (expect_word) begin
            if (ch == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
        drive_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(ch, d[i]);
        if (ch == 1) drive_bit(ch, pbit);
        for (int i = 0; i < ((ch == 0) ? 1 : 2); i++) drive_bit(ch, stop_lvl);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy0 === 1'b1 && bp0 === 1'b0) rise0 = cyc;
        if (busy0 === 1'b0 && bp0 === 1'b1) fall0 = cyc;
        if (busy1 === 1'b1 && bp1 === 1'b0) rise1 = cyc;
        if (vld0 === 1'b1 && vp0 === 1'b0) check_eq("latency0", cyc - rise0, LAT0);
        if (vld1 === 1'b1 && vp1 === 1'b0) check_eq("latency1", cyc - rise1, LAT1);
        if (ovr0 === 1'b1) ovr_cycles0++;
        if (ovr1 === 1'b1) ovr_cycles1++;
        if (vld0 === 1'b1 && rdy0 === 1'b1) begin
            if (q0.size() == 0) begin
                check_eq("extra_word0", data0, 32'hFFFF_FFFF);
            end else begin
                e = q0.pop_front();
                check_eq("data0", data0, e.data);
                check_eq("frame_err0", fe0, e.fe);
                check_eq("parity_err0", pe0, e.pe);
            end
        end
        if (vld1 === 1'b1 && rdy1 === 1'b1) begin
            if (q1.size() == 0) begin
                check_eq("extra_word1", data1, 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                check_eq("data1", data1, e.data);
                check_eq("frame_err1", fe1, e.fe);
                check_eq("parity_err1", pe1, e.pe);
            end
        end
        bp0 = busy0;
        bp1 = busy1;
        vp0 = vld0;
        vp1 = vld1;
    end

    initial begin
        logic [7:0] partial;
        int         waited;
        rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; reset = 1'b1;
        tick(3);
        @(negedge clk);
        check_eq("rst_valid", vld0, 1'b0);
        check_eq("rst_data", data0, 8'h00);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_overrun", ovr0, 1'b0);
        check_eq("rst_flags", {fe0, pe0, fe1, pe1}, 4'b0000);
        @(posedge clk);
        #1 reset = 1'b0;
        tick(5);

        // Back-to-back 8N1 words, consumer always ready
        send(0, 8'hB5, 1'b0, 1'b1, 1'b1);
        send(0, 8'h0A, 1'b0, 1'b1, 1'b1);
        send(0, 8'h08, 1'b0, 1'b1, 1'b1);
        tick(20);

        // Even parity: correct bit, then wrong bit
        send(1, 8'h0C, 1'b0, 1'b1, 1'b1);
        send(1, 8'h0C, 1'b1, 1'b1, 1'b1);
        tick(20);

        // Low stop bit followed by a held-low line
        send(0, 8'h01, 1'b0, 1'b0, 1'b1);
        tick(20);
        check_eq("break_busy", busy0, 1'b1);
        tick(20);
        rx0 = 1'b1;
        tick(10);
        check_eq("break_exit", busy0, 1'b0);

        // Consumer stalled: second word is dropped with an overrun pulse
        rdy0 = 1'b0;
        send(0, 8'h0A, 1'b0, 1'b1, 1'b1);
        send(0, 8'h08, 1'b0, 1'b1, 1'b0);
        tick(20);
        check_eq("hold_valid", vld0, 1'b1);
        check_eq("hold_data", data0, 8'h0A);
        check_eq("overrun_cycles", ovr_cycles0, 1);
        rdy0 = 1'b1;
        tick(2);
        check_eq("hold_clear", vld0, 1'b0);

        // Short glitch on an idle line
        rx0 = 1'b0;
        tick(5);
        rx0 = 1'b1;
        tick(30);
        check_eq("glitch_start_len", fall0 - rise0, CPB / 2);
        check_eq("glitch_idle", busy0, 1'b0);

        // Reset in the middle of a data phase
        partial = 8'hB5;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, partial[i]);
        reset = 1'b1;
        rx0 = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_busy", busy0, 1'b0);
        check_eq("rst_mid_valid", vld0, 1'b0);
        check_eq("rst_mid_data", data0, 8'h00);
        check_eq("rst_mid_flags", {fe0, pe0, ovr0}, 3'b000);
        @(posedge clk);
        #1;
        tick(5);
        send(0, 8'h0A, 1'b0, 1'b1, 1'b1);

        waited = 0;
        while ((q0.size() != 0 || q1.size() != 0) && waited < 500) begin
            tick(1);
            waited++;
        end
        tick(20);
        check_eq("drain0", q0.size(), 0);
        check_eq("drain1", q1.size(), 0);
        check_eq("overrun_total0", ovr_cycles0, 1);
        check_eq("overrun_total1", ovr_cycles1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
